// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO master: frame field codes,
// bit counts, state encodings and the frame legality check.
// Optional feature macro used by the design: MDIO_PREAMBLE_EN.
package mdio_pkg;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;

    localparam int FRAME_BITS    = 32;
    localparam int RD_BITS       = 16;
    localparam int PREAMBLE_BITS = 32;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRE       = 3'd1;
    localparam logic [2:0] SHIFT_OUT = 3'd2;
    localparam logic [2:0] SHIFT_IN  = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = IDLE,
        S_PRE       = PRE,
        S_SHIFT_OUT = SHIFT_OUT,
        S_SHIFT_IN  = SHIFT_IN,
        S_DONE      = DONE
    } state_t;

    // A frame is startable only with the Clause 22 start code and a read or write opcode.
    function automatic logic frame_legal(input logic [31:0] frame);
        return (frame[31:30] == ST_CODE) &&
               ((frame[29:28] == OP_WR) || (frame[29:28] == OP_RD));
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider. While enabled, counts 0..MDC_DIV-1 and toggles MDC at the
// terminal count. rise_tick/fall_tick are high in the cycle whose closing
// edge makes MDC go 0->1 / 1->0, so the controller acts on that same edge.
// Ports: clk, reset (sync, active-high), en, clr (sync clear to MDC=0),
//        mdc (registered), rise_tick, fall_tick.
module mdio_clk_gen #(
    parameter int MDC_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(MDC_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          mdc_r;
    logic          tick_s;

    assign tick_s    = en & (cnt_r == TERM);
    assign rise_tick = tick_s & ~mdc_r;
    assign fall_tick = tick_s & mdc_r;
    assign mdc       = mdc_r;

    // Divider counter and MDC toggle flop.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_r <= '0;
            mdc_r <= 1'b0;
        end else if (en) begin
            if (tick_s) begin
                cnt_r <= '0;
                mdc_r <= ~mdc_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
            mdc_r <= mdc_r;
        end
    end

endmodule

// File: rtl/mdio_controller.sv
// Clause 22 MDIO management master. Accepts a 32-bit frame from the host,
// shifts it MSB-first onto MDIO_OUT (changing on MDC fall, PHY samples on
// rise) and, for reads, releases the line after the turnaround and captures
// 16 data bits from MDIO_IN on MDC rises.
// Ports: CLK, RESET (sync, active-high), T_DATA, T_INI, T_BUSY, T_DONE, ERR,
//        MDC, MDIO_OUT, MDIO_OE, MDIO_IN, RD_DATA.
// Macro MDIO_PREAMBLE_EN: when defined, 32 preamble ones precede each frame.
module mdio_controller
    import mdio_pkg::*;
#(
    parameter int MDC_DIV = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] T_DATA,
    input  logic        T_INI,
    output logic        T_BUSY,
    output logic        T_DONE,
    output logic        ERR,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    input  logic        MDIO_IN,
    output logic [15:0] RD_DATA
);

    localparam logic [4:0] IDX_LAST     = 5'(FRAME_BITS - 1);
    localparam logic [4:0] IDX_TA_END   = 5'(RD_BITS);
    localparam logic [4:0] IDX_RD_FIRST = 5'(RD_BITS - 1);
`ifdef MDIO_PREAMBLE_EN
    localparam logic [4:0] IDX_PRE      = 5'(PREAMBLE_BITS - 1);
`endif

    state_t      state_r;
    logic [31:0] frame_r;
    logic [4:0]  idx_r;
    logic [15:0] shadow_r;
    logic [15:0] rd_data_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        out_r;
    logic        oe_r;

    logic        accept_s;
    logic        en_s;
    logic        rise_tick_s;
    logic        fall_tick_s;
    logic        is_read_s;

    assign T_BUSY   = busy_r;
    assign T_DONE   = done_r;
    assign ERR      = err_r;
    assign MDIO_OUT = out_r;
    assign MDIO_OE  = oe_r;
    assign RD_DATA  = rd_data_r;
    assign is_read_s = (frame_r[29:28] == OP_RD);

    // Accept decode and divider enable (MDC runs only in the shifting states).
    always_comb begin
        accept_s = 1'b0;
        en_s     = 1'b0;
        if (state_r == S_IDLE) begin
            accept_s = T_INI & frame_legal(T_DATA);
        end else begin
            accept_s = 1'b0;
        end
        case (state_r)
            S_PRE, S_SHIFT_OUT, S_SHIFT_IN: en_s = 1'b1;
            default:                        en_s = 1'b0;
        endcase
    end

    mdio_clk_gen #(.MDC_DIV(MDC_DIV)) u_clk_gen (
        .clk       (CLK),
        .reset     (RESET),
        .en        (en_s),
        .clr       (accept_s),
        .mdc       (MDC),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s)
    );

    // Frame sequencer with registered pin and host outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= S_IDLE;
            frame_r   <= 32'h0000_0000;
            idx_r     <= 5'd0;
            shadow_r  <= 16'h0000;
            rd_data_r <= 16'h0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            out_r     <= 1'b0;
            oe_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        frame_r <= T_DATA;
                        busy_r  <= 1'b1;
                        oe_r    <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
                        state_r <= S_PRE;
                        idx_r   <= IDX_PRE;
                        out_r   <= 1'b1;
`else
                        state_r <= S_SHIFT_OUT;
                        idx_r   <= IDX_LAST;
                        out_r   <= T_DATA[31];
`endif
                    end else if (T_INI) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
`ifdef MDIO_PREAMBLE_EN
                S_PRE: begin
                    if (fall_tick_s) begin
                        if (idx_r == 5'd0) begin
                            state_r <= S_SHIFT_OUT;
                            idx_r   <= IDX_LAST;
                            out_r   <= frame_r[31];
                        end else begin
                            idx_r <= idx_r - 5'd1;
                        end
                    end else begin
                        state_r <= S_PRE;
                    end
                end
`endif
                S_SHIFT_OUT: begin
                    if (fall_tick_s) begin
                        if (idx_r == 5'd0) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            oe_r    <= 1'b0;
                            out_r   <= 1'b0;
                        end else if (is_read_s && (idx_r == IDX_TA_END)) begin
                            // Turnaround finished: hand the line to the PHY.
                            state_r <= S_SHIFT_IN;
                            idx_r   <= IDX_RD_FIRST;
                            oe_r    <= 1'b0;
                            out_r   <= 1'b0;
                        end else begin
                            idx_r <= idx_r - 5'd1;
                            out_r <= frame_r[idx_r - 5'd1];
                        end
                    end else begin
                        state_r <= S_SHIFT_OUT;
                    end
                end
                S_SHIFT_IN: begin
                    if (rise_tick_s) begin
                        shadow_r <= {shadow_r[14:0], MDIO_IN};
                    end else if (fall_tick_s) begin
                        if (idx_r == 5'd0) begin
                            state_r   <= S_DONE;
                            done_r    <= 1'b1;
                            rd_data_r <= shadow_r;
                        end else begin
                            idx_r <= idx_r - 5'd1;
                        end
                    end else begin
                        state_r <= S_SHIFT_IN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    oe_r    <= 1'b0;
                    out_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_controller.sv
// Scoreboard bench for mdio_controller: a driver issues frames and pushes
// the expected outcome, a monitor watches the pins and host outputs and
// compares against the popped expectation on every T_DONE/ERR pulse.
module tb_mdio_controller;

`ifdef MDIO_PREAMBLE_EN
    localparam int DIV = 1;
    localparam int PRE = 32;
`else
    localparam int DIV = 2;
    localparam int PRE = 0;
`endif
    localparam int NBITS   = 32 + PRE;
    localparam int LATENCY = 2 * DIV * NBITS + 1;

    logic        CLK;
    logic        RESET;
    logic [31:0] T_DATA;
    logic        T_INI;
    logic        T_BUSY;
    logic        T_DONE;
    logic        ERR;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic [15:0] RD_DATA;

    mdio_controller #(.MDC_DIV(DIV)) dut (
        .CLK(CLK), .RESET(RESET), .T_DATA(T_DATA), .T_INI(T_INI),
        .T_BUSY(T_BUSY), .T_DONE(T_DONE), .ERR(ERR), .MDC(MDC),
        .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .MDIO_IN(MDIO_IN),
        .RD_DATA(RD_DATA)
    );

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 rejected
        logic [31:0] frame;
        logic [15:0] rd;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          phy_r = 0;
    logic [15:0] phy_data = 16'h0000;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] d);
        return (d[31:30] == 2'b01) && (d[29:28] == 2'b01 || d[29:28] == 2'b10);
    endfunction

    // PHY model: after frame rise r (counted past the preamble), rises 16..31
    // present read data bits 15..0; otherwise the line carries noise.
    initial forever begin
        @(posedge MDC);
        #1;
        phy_r++;
        if (phy_r - PRE >= 16 && phy_r - PRE <= 31)
            MDIO_IN = phy_data[31 - (phy_r - PRE)];
        else
            MDIO_IN = 1'($urandom % 2);
    end

    // Monitor: collects bits seen on MDC rises and checks each completion.
    initial begin
        int          nrise = 0;
        int          ncap = 0;
        logic [63:0] cap = 64'h0;
        bit          leak = 0;
        logic        mdc_prev = 1'b0;
        logic [15:0] last_rd = 16'h0000;
        logic [63:0] exp_cap;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                nrise = 0; ncap = 0; cap = 64'h0; leak = 0; last_rd = 16'h0000;
            end else begin
                if (MDC && !mdc_prev) begin
                    nrise++;
                    if (MDIO_OE) begin
                        cap = {cap[62:0], MDIO_OUT};
                        ncap++;
                    end
                end
                if (!MDIO_OE && MDIO_OUT) leak = 1;
                if (!T_BUSY && (MDC || MDIO_OE)) leak = 1;
                if (T_DONE || ERR) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", 64'({ERR, T_DONE}), 64'h0);
                    end else begin
                        e = sb.pop_front();
                        if (e.kind == 2) begin
                            chk("err_pulse", 64'({ERR, T_DONE}), 64'h2);
                            chk("err_latency", 64'(cyc - e.issue), 64'd1);
                            chk("err_mdc_rises", 64'(nrise), 64'd0);
                            chk("err_busy", 64'(T_BUSY), 64'd0);
                        end else begin
                            chk("done_pulse", 64'({ERR, T_DONE}), 64'h1);
                            chk("done_latency", 64'(cyc - e.issue), 64'(LATENCY));
                            chk("mdc_rises", 64'(nrise), 64'(NBITS));
                            chk("done_busy", 64'(T_BUSY), 64'd1);
                            chk("oe_out_rules", 64'(leak), 64'd0);
                            if (e.kind == 1) begin
                                exp_cap = (PRE != 0) ? {16'h0, 32'hFFFF_FFFF, e.frame[31:16]}
                                                     : {48'h0, e.frame[31:16]};
                                chk("rd_driven_bits", 64'(ncap), 64'(PRE + 16));
                                last_rd = e.rd;
                            end else begin
                                exp_cap = (PRE != 0) ? {32'hFFFF_FFFF, e.frame}
                                                     : {32'h0, e.frame};
                                chk("wr_driven_bits", 64'(ncap), 64'(PRE + 32));
                            end
                            chk("frame_bits", cap, exp_cap);
                            chk("rd_data", 64'(RD_DATA), 64'(last_rd));
                        end
                    end
                    nrise = 0; ncap = 0; cap = 64'h0; leak = 0;
                end
            end
            mdc_prev = MDC;
        end
    end

    task automatic issue(input logic [31:0] d, input logic [15:0] phy);
        exp_t e;
        e.kind  = !legal(d) ? 2 : ((d[29:28] == 2'b10) ? 1 : 0);
        e.frame = d;
        e.rd    = phy;
        e.issue = cyc;
        sb.push_back(e);
        phy_data = phy;
        phy_r    = 0;
        T_DATA   = d;
        T_INI    = 1'b1;
        @(negedge CLK);
        T_INI  = 1'b0;
        T_DATA = $urandom;
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] d;
        d = $urandom;
        d[31:30] = 2'b01;
        d[29:28] = ($urandom % 2 == 0) ? 2'b01 : 2'b10;
        return d;
    endfunction

    task automatic run_frame(input logic [31:0] d, input logic [15:0] phy,
                             input bit pulse_busy, input bit b2b);
        bit seen;
        issue(d, phy);
        if (!legal(d)) begin
            repeat (2) @(negedge CLK);
            return;
        end
        if (pulse_busy) begin
            repeat (48) @(negedge CLK);
            T_DATA = ($urandom % 2 == 0) ? rand_legal() : 32'h0196_BEEF;
            T_INI  = 1'b1;
            @(negedge CLK);
            T_INI  = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 4 * LATENCY; i++) begin
            if (T_DONE) begin
                seen = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!seen) begin
            chk("done_timeout", 64'(seen), 64'd1);
            sb.delete();
        end
        if (b2b) begin
            // Request during the DONE cycle must be ignored.
            T_DATA = rand_legal();
            T_INI  = 1'b1;
        end
        @(negedge CLK);
        T_INI = 1'b0;
        if (!b2b) repeat ($urandom_range(0, 3)) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] d;
        int          r;
        RESET   = 1'b1;
        T_INI   = 1'b0;
        T_DATA  = 32'h0;
        MDIO_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_outputs", 64'({T_BUSY, T_DONE, ERR, MDC, MDIO_OUT, MDIO_OE}), 64'h0);
        chk("rst_rd_data", 64'(RD_DATA), 64'h0);
        RESET = 1'b0;
        @(negedge CLK);

        run_frame(32'h5196_BEEF, 16'h0000, 1'b0, 1'b0);
        run_frame(32'h6196_0000, 16'hA5C3, 1'b0, 1'b0);
        run_frame(32'h0196_BEEF, 16'h0000, 1'b0, 1'b0);
        run_frame(32'h4196_BEEF, 16'h0000, 1'b0, 1'b0);
        run_frame(32'h5196_BEEF, 16'h0000, 1'b1, 1'b1);
        run_frame(32'h6123_4567, 16'h3C5A, 1'b0, 1'b0);

        // Abort a read around data bit 10.
        issue(32'h61A5_0000, 16'hFFFF);
        repeat ((32 - 10) * 2 * DIV) @(negedge CLK);
        RESET = 1'b1;
        sb.delete();
        @(negedge CLK);
        chk("abort_outputs", 64'({T_BUSY, MDC, MDIO_OUT, MDIO_OE}), 64'h0);
        chk("abort_rd_data", 64'(RD_DATA), 64'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        run_frame(32'h5A5A_1234, 16'h0000, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                d = $urandom;
                if (r == 0) d[31:30] = ($urandom % 2 == 0) ? 2'b00 : 2'b11;
                else begin
                    d[31:30] = 2'b01;
                    d[29:28] = ($urandom % 2 == 0) ? 2'b00 : 2'b11;
                end
            end else begin
                d = rand_legal();
            end
            run_frame(d, 16'($urandom), 1'($urandom % 2), 1'($urandom % 2));
        end
        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
